// File: rtl/tile_select_ctrl.sv
// Hosts NUM_TILES micro tiles on shared 8-bit buses and switches between them with a quiesce/reset/run sequence.
// Optional macro TILE_SEL_UI_SYNC_EN adds a 2-flop synchronizer on ui_in ahead of the tile input routing.
module tile_select_ctrl #(
  parameter int NUM_TILES    = 4,
  parameter int SEL_W        = 2,
  parameter int DEFAULT_SEL  = 0,
  parameter int GUARD_CYCLES = 2,
  parameter int RST_CYCLES   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             ui_in,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   sel_load,
  input  logic [8*NUM_TILES-1:0] tile_uo,
  output logic [8*NUM_TILES-1:0] tile_ui,
  output logic [NUM_TILES-1:0]   tile_rst_n,
  output logic [NUM_TILES-1:0]   tile_clk_en,
  output logic [7:0]             uo_out,
  output logic [SEL_W-1:0]       active_sel,
  output logic                   busy,
  output logic                   sel_err
);

  typedef enum logic [1:0] {S_RUN, S_QUIESCE, S_RESET_NEW} state_t;

  localparam logic [3:0]       GUARD_INIT = 4'(GUARD_CYCLES - 1);
  localparam logic [3:0]       RST_INIT   = 4'(RST_CYCLES - 1);
  localparam logic [SEL_W:0]   NUM_T      = (SEL_W+1)'(NUM_TILES);
  localparam logic [SEL_W-1:0] DEF_SEL    = SEL_W'(DEFAULT_SEL);

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [SEL_W-1:0] active_sel_nx;
  logic             sel_err_nx;
  logic             switch_ok;
  logic [7:0]       active_uo;
  logic [7:0]       ui_route;

  function automatic logic [NUM_TILES-1:0] onehot(input logic [SEL_W-1:0] s);
    return NUM_TILES'(1) << s;
  endfunction

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    active_sel_nx = active_sel;
    sel_err_nx    = sel_err;
    switch_ok     = 1'b0;
    case (state)
      S_RUN: begin
        if (sel_load) begin
          if ({1'b0, sel_in} >= NUM_T) begin
            sel_err_nx = 1'b1;
          end else if (sel_in != active_sel) begin
            switch_ok     = 1'b1;
            active_sel_nx = sel_in;
            state_nx      = S_QUIESCE;
            cnt_nx        = GUARD_INIT;
          end
        end
      end
      S_QUIESCE: begin
        if (cnt == 4'd0) begin
          state_nx = S_RESET_NEW;
          cnt_nx   = RST_INIT;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_RESET_NEW: begin
        if (cnt == 4'd0) state_nx = S_RUN;
        else             cnt_nx   = cnt - 4'd1;
      end
      default: begin
        state_nx = S_RESET_NEW;
        cnt_nx   = RST_INIT;
      end
    endcase
  end

  always_comb begin
    active_uo = '0;
    for (int k = 0; k < NUM_TILES; k++) begin
      if (active_sel == SEL_W'(k)) active_uo = tile_uo[8*k +: 8];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RESET_NEW;
      cnt         <= RST_INIT;
      active_sel  <= DEF_SEL;
      sel_err     <= 1'b0;
      tile_clk_en <= onehot(DEF_SEL);
      uo_out      <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      active_sel  <= active_sel_nx;
      sel_err     <= sel_err_nx;
      tile_clk_en <= (state_nx == S_QUIESCE) ? '0 : onehot(active_sel_nx);
      // Output is blanked from the strobe onwards so the old tile never leaks into the switch window.
      uo_out      <= (state == S_RUN && state_nx == S_RUN) ? active_uo : 8'h00;
    end
  end

`ifdef TILE_SEL_UI_SYNC_EN
  logic [7:0] ui_s1, ui_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_s1 <= '0;
      ui_s2 <= '0;
    end else if (switch_ok) begin
      ui_s1 <= '0;
      ui_s2 <= '0;
    end else begin
      ui_s1 <= ui_in;
      ui_s2 <= ui_s1;
    end
  end

  assign ui_route = ui_s2;
`else
  assign ui_route = ui_in;
`endif

  // Tile-facing reset and data decode only from registered state, so no input glitch reaches a tile reset.
  always_comb begin
    tile_rst_n = '0;
    tile_ui    = '0;
    if (state == S_RUN) begin
      tile_rst_n = onehot(active_sel);
      for (int k = 0; k < NUM_TILES; k++) begin
        if (active_sel == SEL_W'(k)) tile_ui[8*k +: 8] = ui_route;
      end
    end
  end

  assign busy = (state != S_RUN);

endmodule
